msgdma_ready_latency_adapter: RTL and testbench
===============================================

// Module: msgdma_ready_latency_adapter
// PURPOSE
//  Avalon-ST timing adapter, sink-side counterpart of the mSGDMA input timing adapter.
//  Accepts a readyLatency-0 stream (valid/ready same-cycle) and drives a sink that
//  uses readyLatency = READY_LATENCY (valid allowed only N cycles after ready).
//  A DEPTH-entry FIFO decouples upstream backpressure from the delayed ready.
//  Sits between the mSGDMA read-master data path and a latency>0 streaming sink.
// PARAMETERS
//  DATA_WIDTH     256  payload width in bits
//  READY_LATENCY  2    sink ready latency in cycles; legal 1..8
//  DEPTH          4    FIFO entries; power of two, >= 2
// PORTS
//  clk         in   1                  clock; all logic on rising edge
//  reset_n     in   1                  asynchronous reset, active low
//  in_ready    out  1                  upstream ready (readyLatency 0) = FIFO not full
//  in_valid    in   1                  upstream valid
//  in_data     in   DATA_WIDTH         upstream payload
//  out_ready   in   1                  sink ready (readyLatency READY_LATENCY)
//  out_valid   out  1                  beat presented to sink
//  out_data    out  DATA_WIDTH         sink payload; 0 when out_valid=0
//  fill_level  out  $clog2(DEPTH)+1    current FIFO occupancy 0..DEPTH
// BEHAVIOUR
//  Reset (reset_n=0, async): FIFO empty, wr/rd pointers 0, ready pipe all 0;
//   in_ready=0 while reset asserted, 1 from first clock after release; out_valid=0,
//   out_data=0, fill_level=0. Reset mid-transfer discards all stored beats.
//  Push: in_valid & in_ready at edge writes in_data at wr_ptr; wr_ptr wraps mod DEPTH.
//  in_ready = (fill_level != DEPTH), combinational from registered count. Not full-bypass.
//  Ready pipe: rp[0] <= out_ready; rp[k] <= rp[k-1]; rdy_ok = rp[READY_LATENCY-1],
//   i.e. out_ready sampled exactly READY_LATENCY cycles earlier.
//  Pop: out_valid = rdy_ok & (fill_level != 0), combinational; out_data = head entry.
//   Sink must accept every out_valid beat (it granted ready N cycles earlier);
//   pop advances rd_ptr (wrap mod DEPTH) whenever out_valid=1.
//  Never assert out_valid when rdy_ok=0, even if FIFO non-empty (protocol violation).
//  No empty bypass: beat pushed at edge t is first eligible for out_valid in cycle t+1.
//  Latency in->out minimum 1 cycle, given rdy_ok already 1.
//  Simultaneous push & pop: fill_level unchanged, both pointers advance.
//  Full: in_ready=0; in_valid held by upstream, no overwrite. Pop while full
//   frees a slot; in_ready rises the following cycle (registered count).
//  Empty with rdy_ok=1: out_valid=0; ready opportunity is lost (legal, no beat owed).
//  fill_level = count register, updated +1 push / -1 pop / 0 both; never exceeds DEPTH.
//  out_ready toggling arbitrary; each cycle's grant is independent (no accumulation).
// TESTING  (DATA_WIDTH=256, READY_LATENCY=2, DEPTH=4)
//  1. Reset release, out_ready=1 constantly, push 0xA1..0xA4 back-to-back -> out_valid
//     first high 1 cycle after first push, beats A1..A4 in order, no gaps.
//  2. FIFO empty, push 0x55 at t0 with out_ready=0 until t5, 1 at t5 -> out_valid only
//     at t7, data 0x55; out_valid=0 at t0..t6.
//  3. out_ready=0, push 5 beats -> 4 accepted, in_ready=0 with fill_level=4; raise
//     out_ready for 1 cycle -> exactly one beat out 2 cycles later, in_ready=1 next cycle.
//  4. out_ready pattern 1,0,1,1,0 with FIFO full -> out_valid pattern delayed by 2
//     cycles exactly matches; fill_level decrements only on out_valid cycles.
//  5. Steady push+pop every cycle at fill_level=2 -> fill_level stays 2, order kept.
//  6. Assert reset_n=0 mid-stream with fill_level=3 -> out_valid,fill_level drop to 0
//     immediately (async); after release, next pushed beat 0x99 is first out.

Source files
------------

// File: rtl/msgdma_ready_latency_adapter.sv
// Bridges a readyLatency-0 stream onto a sink with readyLatency = READY_LATENCY.
// A small FIFO absorbs beats while the sink's delayed ready grant is in flight.
module msgdma_ready_latency_adapter #(
  parameter int DATA_WIDTH    = 256,
  parameter int READY_LATENCY = 2,
  parameter int DEPTH         = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  output logic                      in_ready,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [$clog2(DEPTH):0]    fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [CW-1:0]            count;
  logic [READY_LATENCY-1:0] rp;
  logic                     live;
  logic                     rdy_ok;
  logic                     push;
  logic                     pop;

  // live keeps in_ready low while reset is held and for no longer than one clock after
  assign in_ready   = live & (count != CW'(DEPTH));
  assign rdy_ok     = rp[READY_LATENCY-1];
  assign out_valid  = rdy_ok & (count != '0);
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign fill_level = count;
  assign push       = in_valid & in_ready;
  assign pop        = out_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rp     <= '0;
    end else begin
      live  <= 1'b1;
      rp[0] <= out_ready;
      for (int k = 1; k < READY_LATENCY; k++) begin
        rp[k] <= rp[k-1];
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; out_data is masked while out_valid is low
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_msgdma_ready_latency_adapter.sv
// Directed self-checking bench for msgdma_ready_latency_adapter (256-bit, latency 2, depth 4).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
module tb_msgdma_ready_latency_adapter;

  localparam int DW = 256;

  logic          clk;
  logic          reset_n;
  logic          in_ready;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [2:0]    fill_level;

  int total;
  int bad;

  msgdma_ready_latency_adapter #(
    .DATA_WIDTH(DW),
    .READY_LATENCY(2),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_ready(in_ready),
    .in_valid(in_valid),
    .in_data(in_data),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .fill_level(fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++;
    if (fill_level !== 3'd0) begin bad++; $display("FAIL reset_fill got=%0d want=0", fill_level); end
    total++;
    if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    reset_n = 1'b1;
    next_cycle();
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      out_ready = 1'b1;
      in_valid  = (c >= 2 && c <= 5);
      in_data   = in_valid ? DW'(8'hA0 + c - 1) : '0;
      @(negedge clk);
      total++;
      if (out_valid !== (c >= 3 && c <= 6)) begin
        bad++; $display("FAIL b2b_valid cycle=%0d got=%b want=%b", c, out_valid, (c >= 3 && c <= 6));
      end
      if (c >= 3 && c <= 6) begin
        exp_d = DW'(8'hA0 + c - 2);
        total++;
        if (out_data !== exp_d) begin bad++; $display("FAIL b2b_data cycle=%0d got=%h want=%h", c, out_data, exp_d); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_delayed_grant();
    for (int p = 0; p < 2; p++) begin
      next_cycle();
      out_ready = 1'b0;
      in_valid  = 1'b0;
    end
    for (int t = 0; t < 9; t++) begin
      next_cycle();
      in_valid  = (t == 0);
      in_data   = (t == 0) ? DW'(8'h55) : '0;
      out_ready = (t == 5);
      @(negedge clk);
      total++;
      if (out_valid !== (t == 7)) begin
        bad++; $display("FAIL grant_valid t=%0d got=%b want=%b", t, out_valid, (t == 7));
      end
      if (t == 7) begin
        total++;
        if (out_data !== DW'(8'h55)) begin bad++; $display("FAIL grant_data got=%h want=55", out_data); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full();
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      in_valid  = (c <= 8);
      in_data   = DW'(8'hB0 + ((c < 4) ? c + 1 : 5));
      out_ready = (c == 5);
      @(negedge clk);
      if (c == 4) begin
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
        total++;
        if (fill_level !== 3'd4) begin bad++; $display("FAIL full_fill got=%0d want=4", fill_level); end
      end
      if (c >= 5) begin
        total++;
        if (out_valid !== (c == 7)) begin
          bad++; $display("FAIL full_valid cycle=%0d got=%b want=%b", c, out_valid, (c == 7));
        end
        total++;
        if (in_ready !== (c == 8)) begin
          bad++; $display("FAIL full_ready cycle=%0d got=%b want=%b", c, in_ready, (c == 8));
        end
      end
      if (c == 7) begin
        total++;
        if (out_data !== DW'(8'hB1)) begin bad++; $display("FAIL full_data got=%h want=b1", out_data); end
      end
      if (c == 9) begin
        total++;
        if (fill_level !== 3'd4) begin bad++; $display("FAIL refill_fill got=%0d want=4", fill_level); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_ready_pattern();
    logic [4:0] pattern;
    logic [6:0] exp_v;
    int exp_f [7];
    int head;
    pattern = 5'b01101;
    exp_v   = 7'b0110100;
    exp_f   = '{4, 4, 4, 3, 3, 2, 1};
    head    = 2;
    for (int u = 0; u < 7; u++) begin
      next_cycle();
      in_valid  = 1'b0;
      out_ready = (u < 5) ? pattern[u] : 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== exp_v[u]) begin
        bad++; $display("FAIL pattern_valid u=%0d got=%b want=%b", u, out_valid, exp_v[u]);
      end
      total++;
      if (fill_level !== 3'(exp_f[u])) begin
        bad++; $display("FAIL pattern_fill u=%0d got=%0d want=%0d", u, fill_level, exp_f[u]);
      end
      if (exp_v[u]) begin
        total++;
        if (out_data !== DW'(8'hB0 + head)) begin
          bad++; $display("FAIL pattern_data u=%0d got=%h want=%h", u, out_data, DW'(8'hB0 + head));
        end
        head++;
      end
    end
  endtask

  task automatic test_steady();
    logic [DW-1:0] exp_d;
    next_cycle();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = DW'(8'hC1);
    @(negedge clk);
    total++;
    if (fill_level !== 3'd1) begin bad++; $display("FAIL steady_pre_fill got=%0d want=1", fill_level); end
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL steady_pre_valid got=%b want=0", out_valid); end
    for (int k = 2; k < 8; k++) begin
      next_cycle();
      in_valid = 1'b1;
      in_data  = DW'(8'hC0 + k);
      @(negedge clk);
      exp_d = (k == 2) ? DW'(8'hB5) : DW'(8'hC0 + k - 2);
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL steady_valid k=%0d got=%b want=1", k, out_valid); end
      total++;
      if (out_data !== exp_d) begin bad++; $display("FAIL steady_data k=%0d got=%h want=%h", k, out_data, exp_d); end
      total++;
      if (fill_level !== 3'd2) begin bad++; $display("FAIL steady_fill k=%0d got=%0d want=2", k, fill_level); end
    end
  endtask

  task automatic test_reset_mid_stream();
    for (int v = 8; v < 12; v++) begin
      next_cycle();
      in_valid  = (v <= 10);
      in_data   = DW'(8'hD0 + v - 7);
      out_ready = (v != 8);
      @(negedge clk);
    end
    total++;
    if (fill_level !== 3'd3) begin bad++; $display("FAIL mid_pre_fill got=%0d want=3", fill_level); end
    total++;
    if (out_valid !== 1'b1 || out_data !== DW'(8'hD1)) begin
      bad++; $display("FAIL mid_pre_beat got=%b/%h want=1/d1", out_valid, out_data);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%b want=0", out_valid); end
    total++;
    if (fill_level !== 3'd0) begin bad++; $display("FAIL mid_async_fill got=%0d want=0", fill_level); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_async_ready got=%b want=0", in_ready); end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
    in_valid = 1'b1;
    in_data  = DW'(8'h99);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL post_r0_valid got=%b want=0", out_valid); end
    next_cycle();
    in_valid = 1'b0;
    in_data  = '0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_data !== DW'(8'h99)) begin
      bad++; $display("FAIL post_first_beat got=%b/%h want=1/99", out_valid, out_data);
    end
    total++;
    if (fill_level !== 3'd1) begin bad++; $display("FAIL post_fill got=%0d want=1", fill_level); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_back_to_back();
    test_delayed_grant();
    test_full();
    test_ready_pattern();
    test_steady();
    test_reset_mid_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
